approx_mac_sequencer: RTL and testbench
=======================================

Name: approx_mac_sequencer

Overview:
- Sequences a stream of unsigned 8-bit operand pairs through one shared combinational approximate 8x8 Wallace-tree multiplier.
- Accumulates the products into a dot-product result and returns it through a valid/ready handshake.
- Sits between an operand source (memory or testbench FIFO) and the approximate multiplier. The multiplier is instantiated outside this block and connected through the mult_* ports.

Parameters:
- LEN_W, 8, width of the vector-length field; the maximum vector length is 2^LEN_W-1.
- ACC_W, 24, accumulator width in bits; must be at least 16.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a job; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs in the job; sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- mult_a  out  8  registered operand driven to the approximate multiplier.
- mult_b  out  8  registered operand driven to the approximate multiplier.
- mult_p  in  16  approximate product, combinational from mult_a/mult_b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  accumulated sum of products.
- out_ovf  out  1  sticky: the accumulator wrapped at least once during the job.

Behaviour:
- Reset is asynchronous and active-low:
  - state=IDLE;
  - all outputs 0;
  - internal beat counter, pipeline valid bit and accumulator 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1, len!=0 -> LOAD; acc, out_ovf and counter cleared; len latched.
  - start=1, len=0 -> DONE with out_acc=0.
  - start=0 -> remain in IDLE.
- LOAD:
  - in_ready=1 while remaining beats > 0.
  - Beat accepted when in_valid and in_ready are both high; in_a/in_b are registered into mult_a/mult_b and the stage-1 valid bit is set.
  - After the final beat is accepted, go to DRAIN on the next cycle; in_ready=0 from that cycle onward.
- Stage 2: on every cycle with stage-1 valid, acc <= acc + zero-extended mult_p, modulo 2^ACC_W.
  - If that addition carries out of bit ACC_W-1, out_ovf is set.
  - Stage-1 valid clears when no beat is accepted in that cycle.
- Latency:
  - Beat accepted at edge t.
  - mult_a/mult_b are valid after edge t.
  - Its product is in acc after edge t+1.
  - Throughput: 1 beat/cycle.
- DRAIN: wait until stage-1 valid=0, meaning the last product has been added; then -> DONE.
  - Minimum time from the last accept edge to out_valid high: 2 cycles.
- DONE:
  - out_valid=1 and out_acc holds the final sum; both stay stable until out_ready=1.
  - Handshake cycle (out_valid and out_ready both high): -> IDLE, out_valid cleared next cycle.
  - out_acc and out_ovf hold their values until the next start.
- start while busy=1 is ignored; len changes while busy have no effect.
- in_valid gaps in LOAD stall the job; there is no timeout.
- mult_a/mult_b hold their last values when no beat is accepted; the stage-1 valid bit, not the operand values, decides whether accumulation happens.
- Reset asserted mid-job aborts it immediately. No partial result is presented after reset is released.

Optional Feature:
- Macro: APPROX_MAC_ERR_TRACK_EN.
- Defined:
  - Adds output port err_acc[ACC_W-1:0].
  - Each stage-2 cycle computes the exact product mult_a*mult_b internally and adds |exact - mult_p| to err_acc.
  - err_acc is cleared with acc and valid under the same out_valid rules. It saturates at all-ones and does not wrap.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Single beat: start, len=1, (a=15, b=15) -> out_valid 2 cycles after accept; out_acc == mult_p for 15x15 (225 if the multiplier is exact at this point); out_ovf=0.
- Back-to-back: len=4, pairs (1,2), (3,4), (5,6), (7,8), in_valid held high -> in_ready high 4 cycles; out_acc = sum of the 4 mult_p values (100 with an exact model); out_valid 2 cycles after the 4th accept.
- Stall and backpressure:
  - len=3 with in_valid low for 2 cycles mid-job -> same sum as the no-gap run.
  - Hold out_ready=0 for 5 cycles -> out_valid and out_acc stable; IDLE one cycle after out_ready=1.
- Boundaries:
  - len=0 -> DONE next cycle with out_acc=0.
  - ACC_W=16, len=2, (255,255) twice -> out_acc = sum mod 65536; out_ovf=1.
- Reset and ignored start:
  - rst_n low after 2 of 5 beats -> all outputs 0 immediately; a new job of len=1 after release gives the correct result.
  - start pulsed during LOAD -> ignored; the original job completes unchanged.
- APPROX_MAC_ERR_TRACK_EN defined, len=4 with random operands -> err_acc equals the bench-computed sum of |a*b - mult_p|.

Source files
------------

// File: rtl/approx_mac_sequencer_if.sv
// Operand, multiplier and result bus of approx_mac_sequencer.
// master = the sequencer, slave = operand source / multiplier / result consumer.
interface approx_mac_sequencer_if #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 24
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [7:0]       mult_a;
  logic [7:0]       mult_b;
  logic [15:0]      mult_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    input  start, len, in_valid, in_a, in_b, mult_p, out_ready,
    output busy, in_ready, mult_a, mult_b, out_valid, out_acc, out_ovf
  );

  modport slave (
    output start, len, in_valid, in_a, in_b, mult_p, out_ready,
    input  busy, in_ready, mult_a, mult_b, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/approx_mac_sequencer.sv
// Dot-product sequencer around an external approximate 8x8 multiplier.
// Optional APPROX_MAC_ERR_TRACK_EN adds err_acc, the saturating sum of |exact - approx|.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting operand pairs until the beat counter reaches zero
// DRAIN | last product still in flight to the accumulator
// DONE  | result presented, waiting for out_ready
module approx_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  approx_mac_sequencer_if.master bus
`ifdef APPROX_MAC_ERR_TRACK_EN
  ,
  output logic [ACC_W-1:0] err_acc
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             s1_valid;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready;
  logic             accept;
  logic             job_start;
  logic [ACC_W:0]   acc_sum;

  assign in_ready  = (state == LOAD) && (cnt != '0);
  assign accept    = in_ready && bus.in_valid;
  assign job_start = (state == IDLE) && bus.start;
  // Extra top bit of the sum is the carry out of the accumulator.
  assign acc_sum   = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, bus.mult_p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      s1_valid    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
        cnt <= cnt - 1'b1;
      end
      if (s1_valid) begin
        acc_q <= acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W]) ovf_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= bus.len;
            if (bus.len != '0) begin
              state <= LOAD;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept && (cnt == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.mult_a    = a_q;
  assign bus.mult_b    = b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

`ifdef APPROX_MAC_ERR_TRACK_EN
  logic [15:0]      exact;
  logic [15:0]      diff;
  logic [ACC_W:0]   err_sum;
  logic [ACC_W-1:0] err_q;

  assign exact   = {8'b0, a_q} * {8'b0, b_q};
  assign diff    = (exact >= bus.mult_p) ? (exact - bus.mult_p) : (bus.mult_p - exact);
  assign err_sum = {1'b0, err_q} + {{(ACC_W-15){1'b0}}, diff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (job_start) begin
      err_q <= '0;
    end else if (s1_valid) begin
      err_q <= err_sum[ACC_W] ? '1 : err_sum[ACC_W-1:0];
    end
  end

  assign err_acc = err_q;
`endif

endmodule

// File: tb/tb_approx_mac_sequencer.sv
// Scoreboard bench for approx_mac_sequencer: 24-bit and 16-bit accumulator instances.
module tb_approx_mac_sequencer;

  typedef struct packed {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   rdy_cnt;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] va[8];
  logic [7:0] vb[8];

  approx_mac_sequencer_if #(.LEN_W(8), .ACC_W(24)) bus0();
  approx_mac_sequencer_if #(.LEN_W(8), .ACC_W(16)) bus1();

`ifdef APPROX_MAC_ERR_TRACK_EN
  logic [23:0] err0;
  logic [15:0] err1;
`endif

  approx_mac_sequencer #(.LEN_W(8), .ACC_W(24)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
`ifdef APPROX_MAC_ERR_TRACK_EN
    ,
    .err_acc (err0)
`endif
  );

  approx_mac_sequencer #(.LEN_W(8), .ACC_W(16)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef APPROX_MAC_ERR_TRACK_EN
    ,
    .err_acc (err1)
`endif
  );

  // Multiplier stand-in: exact for small operands, low nibble dropped otherwise.
  function automatic logic [15:0] approx_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'b0, a} * {8'b0, b};
    if (a >= 8'd16 || b >= 8'd16) p = p & 16'hFFF0;
    return p;
  endfunction

  assign bus0.mult_p = approx_mul(bus0.mult_a, bus0.mult_b);
  assign bus1.mult_p = approx_mul(bus1.mult_a, bus1.mult_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on every result handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0_unexpected: got acc %0d expected no result", bus0.out_acc);
      end else begin
        e = q0.pop_front();
        chk("sb0_acc", 64'(bus0.out_acc), 64'(e.acc));
        chk("sb0_ovf", 64'(bus0.out_ovf), 64'(e.ovf));
      end
    end
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_unexpected: got acc %0d expected no result", bus1.out_acc);
      end else begin
        e = q1.pop_front();
        chk("sb1_acc", 64'(bus1.out_acc), 64'(e.acc[15:0]));
        chk("sb1_ovf", 64'(bus1.out_ovf), 64'(e.ovf));
      end
    end
    if (bus0.in_ready) rdy_cnt++;
  end

  task automatic feed(input int n, input int gap_at, input int gap_len, input int pulse_at);
    int i, g, guard;
    bit pulsed;
    i = 0; g = 0; guard = 0; pulsed = 0;
    while (i < n && guard < 100) begin
      @(negedge clk);
      guard++;
      bus0.start = 1'b0;
      if (i == pulse_at && !pulsed) begin
        bus0.start = 1'b1;
        bus0.len   = 8'd1;
        pulsed     = 1;
      end
      if (i == gap_at && g < gap_len) begin
        bus0.in_valid = 1'b0;
        g++;
      end else begin
        bus0.in_valid = 1'b1;
        bus0.in_a     = va[i];
        bus0.in_b     = vb[i];
        if (bus0.in_ready) i++;
      end
    end
    if (i < n) begin
      checks++; errors++;
      $display("FAIL feed_timeout: got %0d beats accepted expected %0d", i, n);
    end
    @(negedge clk);
    bus0.in_valid = 1'b0;
    bus0.start    = 1'b0;
  endtask

  task automatic wait_valid0(output int k);
    k = 0;
    while (!bus0.out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_job(input string tag, input int n, input logic [23:0] ea, input logic eo,
                        input int gap_at, input int gap_len, input int pulse_at);
    int k;
    q0.push_back('{acc: ea, ovf: eo});
    @(negedge clk);
    rdy_cnt    = 0;
    bus0.start = 1'b1;
    bus0.len   = 8'(n);
    feed(n, gap_at, gap_len, pulse_at);
    wait_valid0(k);
    chk({tag, "_latency"}, 64'(k), 64'd2);
    @(negedge clk);
    chk({tag, "_idle"}, 64'({bus0.busy, bus0.out_valid}), 64'd0);
  endtask

  initial begin
    int k;
    logic [23:0] held;
    logic        stable;
`ifdef APPROX_MAC_ERR_TRACK_EN
    logic [23:0] ea;
    logic [23:0] ee;
    logic [15:0] ex;
    logic [15:0] ap;
`endif
    checks = 0; errors = 0; rdy_cnt = 0;
    bus0.start = 0; bus0.len = 0; bus0.in_valid = 0; bus0.in_a = 0; bus0.in_b = 0; bus0.out_ready = 1;
    bus1.start = 0; bus1.len = 0; bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0; bus1.out_ready = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 64'({bus0.busy, bus0.in_ready, bus0.mult_a, bus0.mult_b,
                              bus0.out_valid, bus0.out_acc, bus0.out_ovf}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    va[0] = 15; vb[0] = 15;
    do_job("single", 1, 24'd225, 1'b0, -1, 0, -1);

    va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4; va[2] = 5; vb[2] = 6; va[3] = 7; vb[3] = 8;
    do_job("b2b", 4, 24'd100, 1'b0, -1, 0, -1);
    chk("b2b_ready_cycles", 64'(rdy_cnt), 64'd4);

    va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
    do_job("stall", 3, 24'd68, 1'b0, 1, 2, -1);
    do_job("start_in_load", 3, 24'd68, 1'b0, -1, 0, 1);

    // Backpressure: result must hold while out_ready is low.
    bus0.out_ready = 1'b0;
    va[0] = 9; vb[0] = 10; va[1] = 11; vb[1] = 12;
    q0.push_back('{acc: 24'd222, ovf: 1'b0});
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.len   = 8'd2;
    feed(2, -1, 0, -1);
    wait_valid0(k);
    chk("bp_latency", 64'(k), 64'd2);
    held   = bus0.out_acc;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b1 || bus0.out_acc !== held) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    chk("bp_acc", 64'(held), 64'd222);
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", 64'({bus0.busy, bus0.out_valid}), 64'd0);
    chk("bp_hold_acc", 64'(bus0.out_acc), 64'd222);

    // Zero-length job.
    q0.push_back('{acc: 24'd0, ovf: 1'b0});
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.len   = 8'd0;
    @(negedge clk);
    bus0.start = 1'b0;
    chk("len0_valid", 64'(bus0.out_valid), 64'd1);
    chk("len0_acc", 64'(bus0.out_acc), 64'd0);
    @(negedge clk);
    chk("len0_idle", 64'(bus0.busy), 64'd0);

    // 16-bit accumulator wrap: 2 x 65024 = 130048 -> 64512, carry out.
    q1.push_back('{acc: 24'd64512, ovf: 1'b1});
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.len   = 8'd2;
    @(negedge clk);
    bus1.start = 1'b0; bus1.in_valid = 1'b1; bus1.in_a = 8'd255; bus1.in_b = 8'd255;
    @(negedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    k = 0;
    while (!bus1.out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("wrap_latency", 64'(k), 64'd2);
    @(negedge clk);

    // Reset in the middle of a 5-beat job.
    va[0] = 3; vb[0] = 3; va[1] = 4; vb[1] = 4;
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.len   = 8'd5;
    feed(2, -1, 0, -1);
    #3 rst_n = 1'b0;
    #1;
    chk("midjob_reset", 64'({bus0.busy, bus0.in_ready, bus0.mult_a, bus0.mult_b,
                             bus0.out_valid, bus0.out_acc, bus0.out_ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_quiet", 64'({bus0.busy, bus0.out_valid, bus0.out_acc}), 64'd0);
    va[0] = 6; vb[0] = 7;
    do_job("post_reset", 1, 24'd42, 1'b0, -1, 0, -1);

`ifdef APPROX_MAC_ERR_TRACK_EN
    ea = 0; ee = 0;
    for (int i = 0; i < 4; i++) begin
      va[i] = 8'($urandom_range(16, 255));
      vb[i] = 8'($urandom_range(16, 255));
      ex = {8'b0, va[i]} * {8'b0, vb[i]};
      ap = approx_mul(va[i], vb[i]);
      ea = ea + 24'(ap);
      ee = ee + 24'(ex - ap);
    end
    do_job("err", 4, ea, 1'b0, -1, 0, -1);
    chk("err_acc", 64'(err0), 64'(ee));
`endif

    repeat (3) @(negedge clk);
    chk("sb0_drained", 64'(q0.size()), 64'd0);
    chk("sb1_drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
